acc_snapshot_buffer: RTL
========================

# acc_snapshot_buffer

Capture stage directly downstream of the unsigned vector accumulator. On software request it grabs exactly one complete dumped accumulation frame (VECTOR_LEN samples, element 0 first), scales it from the accumulator width to a register-friendly width, and holds it in a BRAM. The held frame is read out through a random-access port with a fixed one-cycle latency. The block also flags frames that arrive while a snapshot is still unread.

## Interface
- DIN_WIDTH, 64, width of the accumulator output sample.
- VECTOR_LEN, 64, samples per frame; power of two, at least 2.
- DOUT_WIDTH, 32, stored and read-back sample width.
- SHIFT, 16, right shift applied before width reduction; 0 ≤ SHIFT < DIN_WIDTH.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  DIN_WIDTH  accumulator dump sample (unsigned).
- din_valid  in  1  din qualifier; may be gapped.
- frame_start  in  1  one-cycle pulse; the same pulse that starts a new accumulation (new_acc) upstream.
- arm  in  1  one-cycle pulse from software: capture the next full frame.
- rd_addr  in  $clog2(VECTOR_LEN)  read address.
- rd_data  out  DOUT_WIDTH  buffer[rd_addr], registered.
- ready  out  1  a complete snapshot is held.
- busy  out  1  armed or capturing.
- missed  out  16  frames started while ready=1; saturates at 0xFFFF.
- resync  out  1  sticky; set when frame_start arrives mid-capture.

## Operation
- States: IDLE, ARMED, CAPTURE, DONE.
- Reset (any state) → IDLE.
  - ready=0, busy=0, missed=0, resync=0, rd_data=0, index=0.
  - BRAM contents are not cleared.
- IDLE: an arm pulse → ARMED.
- ARMED: a frame_start pulse → CAPTURE, with index=0.
- CAPTURE, on each din_valid:
  - write scaled(din) to buffer[index], then index+1.
  - The write of index VECTOR_LEN-1 → DONE.
- CAPTURE, on frame_start:
  - index returns to 0 and the state stays CAPTURE.
  - resync is set; it is cleared only by rst or by the next arm.
- DONE:
  - ready=1.
  - frame_start increments missed (saturating).
  - arm → ARMED: clears ready, resync and missed.
- arm in ARMED or CAPTURE is ignored.
- arm in IDLE or DONE coincident with frame_start: the transition to ARMED happens first, and that same frame_start does not start a capture. In DONE, that frame_start is not counted as missed.
- busy = (state is ARMED or CAPTURE).
- Scaling: s = din >> SHIFT, then reduced to DOUT_WIDTH bits. The reduction method is set under Configuration.
- Read port:
  - Always enabled, in every state.
  - Reads during CAPTURE return whatever is currently stored (old/new mix). This is permitted; software must wait for ready.

## Timing
- A din_valid in the same cycle as frame_start is not captured; it belongs to the previous frame. Capture considers din_valid from the following cycle.
- A captured sample is written to the BRAM in the cycle after its din_valid.
- ready rises in the cycle after the clock edge on which the last sample (index VECTOR_LEN-1) is accepted.
- busy falls in that same cycle.
- Read latency is 1 cycle: rd_data at edge n+1 reflects rd_addr at edge n.
- Read-during-write to the same address returns the old data.
- The index wraps only through DONE. There is never a write beyond VECTOR_LEN-1.
- No writes occur in IDLE, ARMED or DONE, so a held frame is immutable until the next arm and its capture.
- missed updates in the cycle after frame_start.

## Configuration
- ACC_SNAP_SAT_EN defined: saturating reduction. If any bit of s above DOUT_WIDTH-1 is set, the stored value is all ones (2^DOUT_WIDTH-1).
- ACC_SNAP_SAT_EN undefined: plain truncation. The stored value is s[DOUT_WIDTH-1:0].

## Test plan
- Basic capture:
  - Stimulus: VECTOR_LEN=8, SHIFT=0, DIN_WIDTH=64, DOUT_WIDTH=32. arm, then frame_start, then 8 gapped valids with din=10..17.
  - Response: ready one cycle after the 8th valid; rd_addr 0..7 read 10..17, each one cycle after its address.
- Same-cycle exclusion and ARMED behaviour:
  - Stimulus: din_valid with din=99 coincident with frame_start; separately, din_valid in ARMED before any frame_start.
  - Response: neither sample is stored; element 0 is the next valid's din.
- Missed frames:
  - Stimulus: hold in DONE through 3 frame_start pulses, then arm.
  - Response: missed=3 after the pulses; arm clears missed to 0 and ready to 0, busy=1; buffer unchanged until the new capture writes.
- Resync:
  - Stimulus: frame_start after 5 of 8 samples, then 8 samples 100..107.
  - Response: resync=1; buffer reads 100..107; ready asserted.
- Scaling:
  - Stimulus: SHIFT=4, din=0x0000_0123_4567_89A0.
  - Response with ACC_SNAP_SAT_EN: stored 0xFFFFFFFF.
  - Response without: stored 0x3456789A.
- Reset mid-capture:
  - Stimulus: rst after 3 samples.
  - Response: next cycle ready=0, busy=0, missed=0, resync=0, rd_data=0; further din_valid writes nothing until arm and frame_start.

Source files
------------

// File: rtl/acc_snapshot_buffer.sv
// acc_snapshot_buffer
//
// Capture stage that sits directly behind the unsigned vector accumulator.
// When software pulses arm_i, the block waits for the next frame_start_i and
// then stores one complete dumped frame (VECTOR_LEN samples, element 0 first)
// into a block RAM. Each sample is scaled from DIN_WIDTH down to DOUT_WIDTH on
// the way in. The held frame is read back through a random-access port with a
// fixed one-cycle latency.
//
// Optional feature macro: ACC_SNAP_SAT_EN
//   defined   : saturating width reduction (all ones if any dropped bit is set)
//   undefined : plain truncation to the low DOUT_WIDTH bits
//
// Ports:
//   clk_i          single clock, all logic on the rising edge
//   rst_i          synchronous active-high reset
//   din_i          accumulator dump sample (unsigned)
//   din_valid_i    din_i qualifier, may be gapped
//   frame_start_i  one-cycle pulse marking the start of a new accumulation
//   arm_i          one-cycle software pulse: capture the next full frame
//   rd_addr_i      read address into the held frame
//   rd_data_o      registered read data, one cycle after rd_addr_i
//   ready_o        a complete snapshot is held
//   busy_o         armed or capturing
//   missed_o       frames started while a snapshot was held (saturating)
//   resync_o       sticky: a frame_start arrived in the middle of a capture
module acc_snapshot_buffer #(
  parameter int DIN_WIDTH  = 64,
  parameter int VECTOR_LEN = 64,
  parameter int DOUT_WIDTH = 32,
  parameter int SHIFT      = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [DIN_WIDTH-1:0]          din_i,
  input  logic                          din_valid_i,
  input  logic                          frame_start_i,
  input  logic                          arm_i,
  input  logic [$clog2(VECTOR_LEN)-1:0] rd_addr_i,
  output logic [DOUT_WIDTH-1:0]         rd_data_o,
  output logic                          ready_o,
  output logic                          busy_o,
  output logic [15:0]                   missed_o,
  output logic                          resync_o
);

  localparam int ADDR_W = $clog2(VECTOR_LEN);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(VECTOR_LEN - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]            state_q,   state_d;
  logic [ADDR_W-1:0]     index_q,   index_d;
  logic [15:0]           missed_q,  missed_d;
  logic                  resync_q,  resync_d;
  logic                  wr_en_q,   wr_en_d;
  logic [ADDR_W-1:0]     wr_addr_q;
  logic [DOUT_WIDTH-1:0] wr_data_q;
  logic [DOUT_WIDTH-1:0] rd_data_q;
  logic [DOUT_WIDTH-1:0] scaled;

  logic [DOUT_WIDTH-1:0] buffer_mem [VECTOR_LEN];

  // Width reduction of the shifted sample.
`ifdef ACC_SNAP_SAT_EN
  logic [DIN_WIDTH-1:0] shifted;
  assign shifted = din_i >> SHIFT;
  // Any set bit above DOUT_WIDTH-1 clamps the stored value to all ones.
  assign scaled  = ((shifted >> DOUT_WIDTH) != '0) ? '1 : shifted[DOUT_WIDTH-1:0];
`else
  assign scaled  = DOUT_WIDTH'(din_i >> SHIFT);
`endif

  // Next-state logic. An arm in IDLE/DONE wins over a coincident frame_start,
  // so that frame_start neither starts a capture nor counts as missed.
  // A din_valid alongside frame_start belongs to the previous frame.
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    missed_d = missed_q;
    resync_d = resync_q;
    wr_en_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (arm_i) begin
          state_d  = ARMED;
          resync_d = 1'b0;
        end
      end
      ARMED: begin
        if (frame_start_i) begin
          state_d = CAPTURE;
          index_d = '0;
        end
      end
      CAPTURE: begin
        if (frame_start_i) begin
          index_d  = '0;
          resync_d = 1'b1;
        end else if (din_valid_i) begin
          wr_en_d = 1'b1;
          if (index_q == LAST_IDX) begin
            state_d = DONE;
            index_d = '0;
          end else begin
            index_d = index_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (arm_i) begin
          state_d  = ARMED;
          missed_d = '0;
          resync_d = 1'b0;
        end else if (frame_start_i && (missed_q != 16'hFFFF)) begin
          missed_d = missed_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      index_q  <= '0;
      missed_q <= '0;
      resync_q <= 1'b0;
      wr_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      missed_q <= missed_d;
      resync_q <= resync_d;
      wr_en_q  <= wr_en_d;
    end
  end

  // Write address/data stage: the RAM write lands one cycle after din_valid.
  always_ff @(posedge clk_i) begin
    wr_addr_q <= index_q;
    wr_data_q <= scaled;
  end

  // RAM write port, no reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_q) begin
      buffer_mem[wr_addr_q] <= wr_data_q;
    end
  end

  // Registered read port; a same-address write in the same cycle returns old data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= buffer_mem[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;
  assign ready_o   = (state_q == DONE);
  assign busy_o    = (state_q == ARMED) || (state_q == CAPTURE);
  assign missed_o  = missed_q;
  assign resync_o  = resync_q;

endmodule
